// File: rtl/ats21_instr_rx.sv
// ATS21 client instruction receiver: captures two-cycle A/B words, drops Nop/illegal
// opcodes, and issues the survivors to the core one at a time, A before B.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready=1, waiting for req; upper halves captured on req
// WORD2   | lower halves captured, both clients classified
// ISSUE_A | client A instruction presented, waiting for instr_ready
// ISSUE_B | client B instruction presented, waiting for instr_ready
// RESP    | one-cycle completion status on stat
module ats21_instr_rx #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        instr_client,
  output logic [2:0]  instr_opcode,
  output logic [31:0] instr_word
);

  typedef enum logic [2:0] {IDLE, WORD2, ISSUE_A, ISSUE_B, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  OP_NOP  = 3'b000;
  localparam logic [2:0]  OP_ILL  = 3'b100;

  state_t      state;
  logic [15:0] hi_a;
  logic [15:0] hi_b;
  logic [31:0] word_b;
  logic        pend_b;
  logic        ill_flag;
  logic        abort_flag;
  logic [15:0] wait_cnt;

  logic       a_legal, b_legal, any_ill;
  logic       issuing, timeout_hit;
  logic       abort_nxt, ill_nxt;
  logic [1:0] stat_resp;

  always_comb begin
    a_legal     = (hi_a[15:13] != OP_NOP) && (hi_a[15:13] != OP_ILL);
    b_legal     = (hi_b[15:13] != OP_NOP) && (hi_b[15:13] != OP_ILL);
    any_ill     = (hi_a[15:13] == OP_ILL) || (hi_b[15:13] == OP_ILL);
    issuing     = (state == ISSUE_A) || (state == ISSUE_B);
    // A transfer on the timeout edge takes priority over the abort.
    timeout_hit = issuing && !instr_ready && (wait_cnt == TO_LAST);
    abort_nxt   = abort_flag || (req && (state != IDLE)) || timeout_hit;
    ill_nxt     = ill_flag || ((state == WORD2) && any_ill);
    if (abort_nxt)    stat_resp = 2'b11;
    else if (ill_nxt) stat_resp = 2'b10;
    else              stat_resp = 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hi_a         <= '0;
      hi_b         <= '0;
      word_b       <= '0;
      pend_b       <= 1'b0;
      ill_flag     <= 1'b0;
      abort_flag   <= 1'b0;
      wait_cnt     <= '0;
      ready        <= 1'b1;
      stat         <= 2'b00;
      instr_valid  <= 1'b0;
      instr_client <= 1'b0;
      instr_opcode <= '0;
      instr_word   <= '0;
    end else begin
      stat <= 2'b00;
      case (state)
        IDLE: begin
          if (req) begin
            hi_a       <= ctrlA;
            hi_b       <= ctrlB;
            ill_flag   <= 1'b0;
            abort_flag <= 1'b0;
            ready      <= 1'b0;
            state      <= WORD2;
          end
        end
        WORD2: begin
          word_b     <= {hi_b, ctrlB};
          pend_b     <= b_legal;
          abort_flag <= abort_nxt;
          ill_flag   <= ill_nxt;
          wait_cnt   <= '0;
          if (a_legal) begin
            instr_valid  <= 1'b1;
            instr_client <= 1'b0;
            instr_opcode <= hi_a[15:13];
            instr_word   <= {hi_a, ctrlA};
            state        <= ISSUE_A;
          end else if (b_legal) begin
            instr_valid  <= 1'b1;
            instr_client <= 1'b1;
            instr_opcode <= hi_b[15:13];
            instr_word   <= {hi_b, ctrlB};
            state        <= ISSUE_B;
          end else begin
            stat  <= stat_resp;
            state <= RESP;
          end
        end
        ISSUE_A, ISSUE_B: begin
          abort_flag <= abort_nxt;
          if (instr_ready) begin
            if ((state == ISSUE_A) && pend_b) begin
              instr_client <= 1'b1;
              instr_opcode <= word_b[31:29];
              instr_word   <= word_b;
              wait_cnt     <= '0;
              state        <= ISSUE_B;
            end else begin
              instr_valid <= 1'b0;
              stat        <= stat_resp;
              state       <= RESP;
            end
          end else if (timeout_hit) begin
            instr_valid <= 1'b0;
            stat        <= stat_resp;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready       <= 1'b1;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_instr_rx.sv
// Bench for ats21_instr_rx: directed and random transactions checked cycle by cycle
// against a transaction-timeline model of the receiver.
module tb_ats21_instr_rx;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [15:0] ctrlA = '0;
  logic [15:0] ctrlB = '0;
  logic        instr_ready = 1'b0;
  logic        ready;
  logic [1:0]  stat;
  logic        instr_valid;
  logic        instr_client;
  logic [2:0]  instr_opcode;
  logic [31:0] instr_word;

  int n_chk  = 0;
  int n_pass = 0;

  ats21_instr_rx #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .stat(stat), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_client(instr_client), .instr_opcode(instr_opcode), .instr_word(instr_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"}, 32'(ready), 32'd1);
    check({tag, " stat"}, 32'(stat), 32'd0);
    check({tag, " valid"}, 32'(instr_valid), 32'd0);
    check({tag, " client"}, 32'(instr_client), 32'd0);
    check({tag, " opcode"}, 32'(instr_opcode), 32'd0);
    check({tag, " word"}, instr_word, 32'd0);
  endtask

  function automatic bit is_legal(input logic [15:0] upper);
    return (upper[15:13] != 3'd0) && (upper[15:13] != 3'd4);
  endfunction

  // gmode: 0 = no extra req, 1 = extra req one cycle after the real one, 2 = random cycle
  task automatic run_txn(input logic [15:0] ua, input logic [15:0] la,
                         input logic [15:0] ub, input logic [15:0] lb,
                         input bit [63:0] rdy, input int gmode, input string name);
    bit          ev[64];
    int          ec[64];
    int          pend[$];
    int          t, w, resp, g;
    bit          ab, ill, done;
    logic [31:0] wd [2];
    logic [1:0]  st;
    wd[0] = {ua, la};
    wd[1] = {ub, lb};
    if (is_legal(ua)) pend.push_back(0);
    if (is_legal(ub)) pend.push_back(1);
    ill = (ua[15:13] == 3'd4) || (ub[15:13] == 3'd4);
    for (int i = 0; i < 64; i++) begin ev[i] = 1'b0; ec[i] = 0; end
    t  = 1;
    ab = 1'b0;
    for (int i = 0; i < pend.size() && !ab; i++) begin
      w = 0;
      done = 1'b0;
      while (!done) begin
        ev[t] = 1'b1;
        ec[t] = pend[i];
        if (rdy[t]) done = 1'b1;
        else begin
          w++;
          if (w == TO) begin ab = 1'b1; done = 1'b1; end
        end
        t++;
      end
    end
    resp = t;
    if (gmode == 1)      g = 0;
    else if (gmode == 2) g = int'($urandom_range(0, resp));
    else                 g = -1;
    // an extra req during RESP arrives too late to change that status
    if (g >= 0 && g < resp) ab = 1'b1;
    st = ab ? 2'b11 : (ill ? 2'b10 : 2'b01);

    check({name, " idle ready"}, 32'(ready), 32'd1);
    req = 1'b1; ctrlA = ua; ctrlB = ub; instr_ready = 1'($urandom);
    @(posedge clk); #1;
    for (int n = 0; n <= resp + 1; n++) begin
      check($sformatf("%s c%0d ready", name, n), 32'(ready), 32'(n == resp + 1));
      check($sformatf("%s c%0d stat", name, n), 32'(stat), (n == resp) ? 32'(st) : 32'd0);
      check($sformatf("%s c%0d valid", name, n), 32'(instr_valid), 32'(ev[n]));
      if (ev[n]) begin
        check($sformatf("%s c%0d client", name, n), 32'(instr_client), 32'(ec[n]));
        check($sformatf("%s c%0d opcode", name, n), 32'(instr_opcode), 32'(wd[ec[n]][31:29]));
        check($sformatf("%s c%0d word", name, n), instr_word, wd[ec[n]]);
      end
      req         = (n == g);
      ctrlA       = (n == 0) ? la : 16'($urandom);
      ctrlB       = (n == 0) ? lb : 16'($urandom);
      instr_ready = rdy[n];
      if (n <= resp) begin @(posedge clk); #1; end
    end
    req = 1'b0;
  endtask

  function automatic logic [15:0] rand_upper();
    logic [2:0] op;
    op = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
    return {op, 13'($urandom)};
  endfunction

  initial begin
    bit [63:0] r;
    int        mode;

    reset = 1'b0;
    #12;
    check_reset_vals("in reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after release");

    run_txn(16'h2000, 16'h0000, 16'h2280, 16'h0000, '1, 0, "both_ok");
    run_txn(16'hA080, 16'h0025, 16'h0000, 16'h0000, '1, 0, "a_only");
    run_txn(16'h8000, 16'h0000, 16'hC101, 16'h0010, '1, 0, "a_illegal");
    run_txn(16'h2000, 16'h1234, 16'h4000, 16'h5678, 64'h0, 0, "timeout");
    run_txn(16'h6000, 16'h00AA, 16'hE000, 16'h00BB, 64'hFFFF_FFFF_FFFF_FFF1, 0, "late_xfer");
    run_txn(16'h2000, 16'hBEEF, 16'h0000, 16'h0000, '1, 1, "extra_req");
    run_txn(16'h0000, 16'h1111, 16'h0000, 16'h2222, '1, 0, "both_nop");
    run_txn(16'h8000, 16'h1111, 16'h9FFF, 16'h2222, '1, 0, "both_illegal");

    // reset while client B is being issued
    check("rst idle ready", 32'(ready), 32'd1);
    req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h6000; instr_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; ctrlA = 16'h0001; ctrlB = 16'h0002;
    @(posedge clk); #1;
    check("rst issue_a client", 32'(instr_client), 32'd0);
    @(posedge clk); #1;
    check("rst issue_b valid", 32'(instr_valid), 32'd1);
    check("rst issue_b client", 32'(instr_client), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post reset idle");
    run_txn(16'h3000, 16'h4321, 16'h0000, 16'h0000, '1, 0, "post_reset");

    for (int k = 0; k < 200; k++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      r = '1;
      else if (mode == 1) r = {$urandom, $urandom};
      else                r = {$urandom, $urandom} & {$urandom, $urandom};
      run_txn(rand_upper(), 16'($urandom), rand_upper(), 16'($urandom), r,
              ($urandom_range(0, 3) == 0) ? 2 : 0, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ats21_instr_rx.md
# ats21_instr_rx

Client-side instruction receiver for the ATS21 timer/alarm core. It captures the two-cycle, 16-bit-per-cycle instruction words presented concurrently by clients A and B, decodes the 3-bit opcode, drops Nop and illegal words, and issues the surviving 32-bit instructions to the core one at a time over a valid/ready handshake, A before B. It drives the client-facing `ready`/`stat` response and sits between the external `req`/`ctrlA`/`ctrlB` pins and the ATS21 command-execution logic.

## Interface
- `TIMEOUT`, 255: max cycles `instr_valid` may wait for `instr_ready` before the pending instruction is aborted; legal range 1..65535.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req`  in  1  client request strobe; one-cycle pulse qualifying the first word.
- `ctrlA`  in  16  client A word: upper half in the `req` cycle, lower half the next cycle.
- `ctrlB`  in  16  client B word, same timing as `ctrlA`.
- `ready`  out  1  1 = receiver idle and will accept `req`.
- `stat`  out  2  one-cycle completion status: 00 none, 01 ok, 10 illegal opcode dropped, 11 aborted/protocol error.
- `instr_valid`  out  1  instruction presented to core.
- `instr_ready`  in  1  core accepts the instruction when high with `instr_valid`.
- `instr_client`  out  1  0 = from A, 1 = from B.
- `instr_opcode`  out  3  bits [31:29] of the instruction.
- `instr_word`  out  32  {upper half, lower half} as captured.

## Operation
- Opcodes: 000 Nop (client not requesting), 001 set clock, 010 enable/disable clock, 011 set mode, 101 set alarm, 110 set countdown, 111 enable/disable alarm/timer; 100 is illegal.
- States: IDLE, WORD2, ISSUE_A, ISSUE_B, RESP.
- IDLE: `ready`=1. On a rising edge with `req`=1, register `ctrlA`/`ctrlB` as upper halves, clear error flags, go to WORD2.
- WORD2: next edge registers the lower halves unconditionally. Classify each client: Nop → skip; 100 → skip and set illegal flag; otherwise pending. Next state: ISSUE_A if A pending, else ISSUE_B if B pending, else RESP.
- ISSUE_A/ISSUE_B: `instr_valid`=1 with the client's fields, stable until transfer. Transfer on an edge where `instr_valid`&`instr_ready`; then go to ISSUE_B if B pending, else RESP.
- Timeout: a 16-bit wait counter clears on ISSUE entry and increments each ISSUE cycle without transfer; when it reaches `TIMEOUT`, the current and any remaining instruction are dropped, the abort flag is set, and the state goes to RESP.
- `req`=1 in any state other than IDLE is ignored, including during WORD2 where that cycle's data is still taken as the lower half; it sets the abort flag.
- RESP: one cycle only, `stat` = 11 if abort flag, else 10 if illegal flag, else 01. This includes the both-Nop case, which reports 01. Then IDLE.
- `stat` is 00 in every state except RESP.

## Timing
- Reset (async assert, synchronous-edge release): state IDLE, `ready`=1, `stat`=00, `instr_valid`=0, `instr_client`=0, `instr_opcode`=0, `instr_word`=0, counter and flags 0.
- Reset mid-operation discards all captured and pending instructions; no `stat` is reported for them.
- All outputs are registered or decoded only from state registers; no combinational path from inputs to outputs.
- `req` sampled at edge T0. Lower halves captured at T1. `instr_valid` is visible after T1 when A or B is pending.
- Minimum transaction: with `instr_ready` tied high, A-only gives valid in cycle T1–T2, RESP in T2–T3, and `ready`=1 after T3. Both-pending adds one cycle.
- Nop-only or illegal-only: RESP in T1–T2, `ready`=1 after T2.
- `ready`=0 from the T0 edge until the RESP cycle ends; a new `req` is accepted at the first edge with `ready`=1.
- Timeout: abort occurs exactly `TIMEOUT` cycles after ISSUE entry with no transfer. A transfer on the same edge as the timeout wins and is not aborted.

## Test plan
- Send A=0x2000_0000, B=0x2280_0000 with `instr_ready`=1 → two transfers in order: client 0 opcode 001, then client 1 word 0x2280_0000; `stat`=01 for one cycle; `ready` returns 1 four cycles after `req`.
- Send A=0xA080_0025, B=0 → single transfer, client 0, opcode 101, word 0xA080_0025; `stat`=01.
- Send A=0x8000_0000 (illegal), B=0xC101_0010 → only B issued; `stat`=10.
- Hold `instr_ready`=0 with `TIMEOUT`=4 and A legal → `instr_valid` high exactly 4 cycles, then drops; B is not issued; `stat`=11.
- Assert `req` again one cycle after the first `req` → second `req` ignored; the original instruction is still issued with its second-cycle data as the lower half; `stat`=11.
- Assert `reset`=0 while in ISSUE_B → all outputs return to reset values immediately; after release, a fresh A-only request completes normally with `stat`=01.
